// File: rtl/pixel_fetch.sv
// Framebuffer prefetcher: a three-state fetch FSM streams words into a small FIFO that feeds
// the display one pixel per enabled cycle. Define PIXEL_FETCH_SCALE4_EN for a 160x120 source upscaled x4.
module pixel_fetch #(
  parameter int          FIFO_DEPTH       = 16,
  parameter logic [11:0] UNDERFLOW_COLOUR = 12'hF0F,
  parameter int          RESTART_ROW      = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  row,
  input  logic [9:0]  column,
  input  logic        en,
  output logic [11:0] colour_data,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic            gap_q;
  logic [11:0]     fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     count_q;
  logic [11:0]     colour_q, colour_d;
  logic            uflow_q;

  logic restart, ack_taken, last_word, fifo_empty, push, pop, flush, uflow_hit;
  logic [11:0] head;

  assign restart     = (row == 10'(RESTART_ROW)) && (column == 10'd0);
  assign ack_taken   = mem_ack && mem_req;
  assign fifo_empty  = (count_q == '0);
  assign head        = fifo_q[rd_q];
  assign colour_data = colour_q;
  assign underflow   = uflow_q;

  // A request stays up while it is outstanding because only an ack can grow the FIFO.
  assign mem_req = (state_q == REQ) && !gap_q &&
                   (pending_q || (count_q < (AW+1)'(FIFO_DEPTH)));

`ifdef PIXEL_FETCH_SCALE4_EN
  logic [7:0]  scol_q;
  logic [1:0]  pass_q;
  logic [6:0]  srow_q;
  logic [1:0]  rep_q;
  logic [11:0] held_q;

  assign mem_addr  = 19'(srow_q) * 19'd160 + 19'(scol_q);
  assign last_word = (srow_q == 7'd119) && (pass_q == 2'd3) && (scol_q == 8'd159);
  assign pop       = en && (rep_q == 2'd0) && !fifo_empty;
  assign uflow_hit = en && (rep_q == 2'd0) && fifo_empty;

  always_comb begin
    colour_d = 12'h000;
    if (en) begin
      if (rep_q != 2'd0)    colour_d = held_q;
      else if (!fifo_empty) colour_d = head;
      else                  colour_d = UNDERFLOW_COLOUR;
    end
  end

  // Each source row is fetched four times (pass_q) before moving to the next source row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scol_q <= '0;
      pass_q <= '0;
      srow_q <= '0;
      rep_q  <= '0;
      held_q <= '0;
    end else begin
      if (flush) begin
        scol_q <= '0;
        pass_q <= '0;
        srow_q <= '0;
      end else if (push) begin
        if (scol_q == 8'd159) begin
          scol_q <= '0;
          pass_q <= pass_q + 2'd1;
          if (pass_q == 2'd3) srow_q <= srow_q + 7'd1;
        end else begin
          scol_q <= scol_q + 8'd1;
        end
      end
      if (flush)                                   rep_q <= '0;
      else if (en && (rep_q != 2'd0 || !fifo_empty)) rep_q <= rep_q + 2'd1;
      if (pop) held_q <= head;
    end
  end
`else
  logic [18:0] ptr_q;

  assign mem_addr  = ptr_q;
  assign last_word = (ptr_q == 19'd307199);
  assign pop       = en && !fifo_empty;
  assign uflow_hit = en && fifo_empty;

  always_comb begin
    colour_d = 12'h000;
    if (en) colour_d = fifo_empty ? UNDERFLOW_COLOUR : head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr_q <= '0;
    else if (flush) ptr_q <= '0;
    else if (push)  ptr_q <= ptr_q + 19'd1;
  end
`endif

  // A restart during an outstanding request waits for its ack, drops that word, then flushes.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    flush     = 1'b0;
    push      = 1'b0;
    case (state_q)
      REQ: begin
        if (ack_taken) begin
          if (pending_q || restart) begin
            flush     = 1'b1;
            pending_d = 1'b0;
          end else begin
            push = 1'b1;
            if (last_word) state_d = DONE;
          end
        end else if (restart && !pending_q) begin
          if (mem_req) pending_d = 1'b1;
          else         flush     = 1'b1;
        end
      end
      default: begin
        if (restart) begin
          flush   = 1'b1;
          state_d = REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      gap_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      colour_q  <= 12'h000;
      uflow_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_q     <= ack_taken;
      colour_q  <= colour_d;
      uflow_q   <= flush ? 1'b0 : (uflow_q | uflow_hit);
      if (flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Randomized bench for pixel_fetch: a frame-level reference model predicts fetch addresses,
// request behaviour and the pixel stream; a monitor compares each output cycle from a queue.
module tb_pixel_fetch;

  localparam int          DEPTH = 16;
  localparam logic [11:0] UF    = 12'hF0F;
`ifdef PIXEL_FETCH_SCALE4_EN
  localparam int TOTAL = 76800;
  localparam int REPS  = 4;
`else
  localparam int TOTAL = 307200;
  localparam int REPS  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  row, column;
  logic        en;
  logic [11:0] colour_data;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic        underflow;

  pixel_fetch #(.FIFO_DEPTH(DEPTH), .UNDERFLOW_COLOUR(UF), .RESTART_ROW(480)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .en(en),
    .colour_data(colour_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  bit          spur = 1'b0;
  int          waitCnt = 0;
  logic [31:0] seed;
  logic [12:0] expQ[$];
  logic [11:0] fifoQ[$];

  function automatic logic [11:0] memWord(int a);
    logic [31:0] x;
    x = (32'(a) * 32'h9E3779B1) ^ seed;
    return x[23:12];
  endfunction

  // Word k of a frame, in fetch order, mapped to its framebuffer address.
  function automatic int expAddr(int k);
    if (REPS == 1) return k;
    return (k / 640) * 160 + (k % 640) % 160;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(int cycles, int enPct, bit doRestart);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #2;
      en     = ($urandom_range(0, 99) < enPct);
      row    = 10'($urandom_range(0, 479));
      column = 10'($urandom_range(0, 639));
      if (doRestart && i == 0) begin
        row    = 10'd480;
        column = 10'd0;
        en     = 1'b0;
      end
    end
  endtask

  // Memory slave: acks after lat waiting cycles, occasionally acks with no request.
  initial begin : slave
    mem_ack   = 1'b0;
    mem_rdata = 12'h000;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (waitCnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(int'(mem_addr));
          waitCnt   = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        if (spur && $urandom_range(0, 7) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 12'($urandom);
        end
      end
    end
  end

  // Reference model: snapshot inputs mid-cycle, apply the frame rules at the clock edge.
  initial begin : model
    bit          sRst, sEn, sAck, sReq, sRestart;
    logic [18:0] sAddr, prevAddr;
    bit          mActive, pend, uflow, prevHs, prevReq, hs, expReq;
    int          k, repCnt, preSize;
    logic [11:0] held, col;
    mActive = 0; pend = 0; uflow = 0; prevHs = 0; prevReq = 0;
    k = 0; repCnt = 0; held = 12'h000; prevAddr = '0;
    forever begin
      @(negedge clk);
      sRst = rst; sEn = en; sAck = mem_ack; sReq = mem_req; sAddr = mem_addr;
      sRestart = (row == 10'd480) && (column == 10'd0);
      @(posedge clk);
      if (sRst) begin
        fifoQ.delete();
        mActive = 0; pend = 0; uflow = 0; prevHs = 0; prevReq = 0; k = 0; repCnt = 0;
        expQ.push_back(13'h0);
      end else begin
        preSize = fifoQ.size();
        expReq  = mActive && !prevHs && (pend || preSize < DEPTH);
        checkOutput("mem_req", 32'(sReq), 32'(expReq));
        if (sReq && prevReq && !prevHs) checkOutput("addrStable", 32'(sAddr), 32'(prevAddr));
        hs = sReq && sAck;
        if (hs && mActive && !pend) checkOutput("mem_addr", 32'(sAddr), 32'(expAddr(k)));
        col = 12'h000;
        if (sEn) begin
          if (repCnt != 0) begin
            col = held;
            repCnt = (repCnt + 1) % REPS;
          end else if (fifoQ.size() > 0) begin
            held = fifoQ.pop_front();
            col = held;
            repCnt = 1 % REPS;
          end else begin
            col = UF;
            uflow = 1;
          end
        end
        if (!mActive) begin
          if (sRestart) begin
            fifoQ.delete(); k = 0; uflow = 0; repCnt = 0; pend = 0; mActive = 1;
          end
        end else if (hs) begin
          if (pend || sRestart) begin
            fifoQ.delete(); k = 0; uflow = 0; repCnt = 0; pend = 0;
          end else begin
            fifoQ.push_back(memWord(expAddr(k)));
            k++;
            if (k == TOTAL) mActive = 0;
          end
        end else if (sRestart && !pend) begin
          if (sReq) pend = 1;
          else begin
            fifoQ.delete(); k = 0; uflow = 0; repCnt = 0;
          end
        end
        prevHs = hs; prevReq = sReq; prevAddr = sAddr;
        expQ.push_back({col, uflow});
      end
    end
  end

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(posedge clk); #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("colour_data", 32'(colour_data), 32'(e[12:1]));
        checkOutput("underflow", 32'(underflow), 32'(e[0]));
      end
    end
  end

  initial begin : stimulus
    bit found;
    seed = $urandom;
    rst = 1'b1; en = 1'b0; row = 10'd0; column = 10'd0;
    #1;
    checkOutput("rstReq", 32'(mem_req), 32'd0);
    checkOutput("rstAddr", 32'(mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(6, 0, 0);
    lat = 1;
    applyStimulus(70, 0, 1);
    spur = 1'b1;
    for (int b = 0; b < 6; b++) begin
      lat = $urandom_range(0, 3);
      applyStimulus(150, 50, 0);
    end
    lat = 0;
    applyStimulus(60, 0, 0);
    applyStimulus(150, 60, 0);
    lat = 3;
    applyStimulus(80, 100, 0);
    applyStimulus(20, 0, 1);
    lat = 5;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #3;
      if (mem_req && !mem_ack && waitCnt == 1) found = 1'b1;
    end
    checkOutput("reqWait", 32'(found), 32'd1);
    row = 10'd480; column = 10'd0; en = 1'b0;
    applyStimulus(60, 30, 0);
    lat = 1;
    applyStimulus(40, 50, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("midColour", 32'(colour_data), 32'd0);
    checkOutput("midReq", 32'(mem_req), 32'd0);
    checkOutput("midAddr", 32'(mem_addr), 32'd0);
    checkOutput("midUflow", 32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(10, 50, 0);
    applyStimulus(30, 0, 1);
    lat = $urandom_range(0, 2);
    applyStimulus(300, 40, 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
